// File: rtl/multicycle_control_unit_if.sv
// Purpose : bundle between the multi-cycle control unit and the datapath/IR/memory port.
// Signals : opcode/funct (IR fields) and mem_ready flow into the controller; datapath
//           mux selects, write strobes, memory requests, alu_op, branch_type, the sticky
//           illegal flag and the debug state flow out.
// Modports: master = control unit, slave = datapath / memory side.
interface multicycle_control_unit_if #(
   parameter int unsigned ALUOP_W = 5
);
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic [1:0]         pc_source;
   logic               ir_write;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic               reg_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               is_jal;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUOP_W-1:0] alu_op;
   logic [2:0]         branch_type;
   logic               illegal;
   logic [3:0]         state;

   modport master (
      input  opcode, funct, mem_ready,
      output pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write,
             reg_write, reg_dst, mem_to_reg, is_jal, alu_src_a, alu_src_b, alu_op,
             branch_type, illegal, state
   );

   modport slave (
      output opcode, funct, mem_ready,
      input  pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write,
             reg_write, reg_dst, mem_to_reg, is_jal, alu_src_a, alu_src_b, alu_op,
             branch_type, illegal, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Purpose : multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP/TRAP) driving
//           a shared datapath and a single ready-handshaked memory port, with a memory-latency
//           watchdog, sticky illegal-instruction trap and optional custom opcode 011111.
// Ports   : i_clk - rising-edge clock; i_rst - asynchronous active-high reset;
//           bus   - multicycle_control_unit_if.master (IR fields, mem_ready in; controls out).
// Custom opcode 011111 functs: 010001 bgt, 010010 bgte, 010011 ble, 010100 bleq,
//           010101 bleu, 010110 bgtu (branch_type = funct[2:0] + 1), 101000 seq.
module multicycle_control_unit #(
   parameter int unsigned ALUOP_W       = 5,
   parameter int unsigned MEM_TIMEOUT   = 16,
   parameter bit          ENABLE_CUSTOM = 1'b1
) (
   input logic                       i_clk,
   input logic                       i_rst,
   multicycle_control_unit_if.master bus
);
   typedef enum logic [3:0] {
      StIdle = 4'd0, StFetch = 4'd1, StDecode = 4'd2, StExec = 4'd3, StMem = 4'd4,
      StWb = 4'd5, StBranch = 4'd6, StJump = 4'd7, StTrap = 4'd8
   } state_e;

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [4:0] AluAdd = 5'b00000, AluSub = 5'b00001, AluAddu = 5'b00010,
                          AluSubu = 5'b00011, AluAnd = 5'b01000, AluOr = 5'b01001,
                          AluXor = 5'b01010, AluSll = 5'b01100, AluSrl = 5'b01101,
                          AluSra = 5'b01110, AluLui = 5'b01111, AluSlt = 5'b10000,
                          AluSeq = 5'b10001;

   state_e           r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;

   // Instruction class decode from the IR fields
   logic       w_rtype, w_r_ok, w_jr, w_itype, w_lw, w_sw, w_br, w_j, w_jal;
   logic       w_custom, w_seq, w_cbr, w_to_exec, w_to_branch, w_to_jump, w_timeout;
   logic [4:0] w_r_alu, w_i_alu;
   logic [2:0] w_br_type;

   always_comb begin
      w_rtype  = (bus.opcode == 6'b000000);
      w_r_ok   = 1'b1;
      w_r_alu  = AluAdd;
      unique case (bus.funct)
         6'b100000: w_r_alu = AluAdd;
         6'b100001: w_r_alu = AluAddu;
         6'b100010: w_r_alu = AluSub;
         6'b100011: w_r_alu = AluSubu;
         6'b100100: w_r_alu = AluAnd;
         6'b100101: w_r_alu = AluOr;
         6'b100110: w_r_alu = AluXor;
         6'b101010: w_r_alu = AluSlt;
         6'b000000: w_r_alu = AluSll;
         6'b000010: w_r_alu = AluSrl;
         6'b000011: w_r_alu = AluSra;
         6'b001000: w_r_alu = AluAdd;   // jr, ALU unused
         default:   w_r_ok  = 1'b0;
      endcase
      w_jr    = w_rtype && (bus.funct == 6'b001000);
      w_itype = 1'b1;
      w_i_alu = AluAdd;
      unique case (bus.opcode)
         6'b001000: w_i_alu = AluAdd;
         6'b001001: w_i_alu = AluAddu;
         6'b001100: w_i_alu = AluAnd;
         6'b001101: w_i_alu = AluOr;
         6'b001110: w_i_alu = AluXor;
         6'b001111: w_i_alu = AluLui;
         default:   w_itype = 1'b0;
      endcase
      w_lw      = (bus.opcode == 6'b100011);
      w_sw      = (bus.opcode == 6'b101011);
      w_br      = (bus.opcode == 6'b000100) || (bus.opcode == 6'b000101);
      w_j       = (bus.opcode == 6'b000010);
      w_jal     = (bus.opcode == 6'b000011);
      w_custom  = ENABLE_CUSTOM && (bus.opcode == 6'b011111);
      w_seq     = w_custom && (bus.funct == 6'b101000);
      w_cbr     = w_custom && (bus.funct >= 6'b010001) && (bus.funct <= 6'b010110);
      w_br_type = w_cbr ? 3'(bus.funct[2:0] + 3'd1) : {2'b00, bus.opcode[0]};
      w_to_exec   = (w_rtype && w_r_ok && !w_jr) || w_itype || w_lw || w_sw || w_seq;
      w_to_branch = w_br || w_cbr;
      w_to_jump   = w_j || w_jal || w_jr;
      w_timeout   = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:   w_state_d = StFetch;
         StFetch: begin
            if (bus.mem_ready)  w_state_d = StDecode;
            else if (w_timeout) w_state_d = StTrap;
         end
         StDecode: begin
            if (w_to_exec)        w_state_d = StExec;
            else if (w_to_branch) w_state_d = StBranch;
            else if (w_to_jump)   w_state_d = StJump;
            else                  w_state_d = StTrap;
         end
         StExec:   w_state_d = (w_lw || w_sw) ? StMem : StWb;
         StMem: begin
            if (bus.mem_ready)  w_state_d = w_lw ? StWb : StFetch;
            else if (w_timeout) w_state_d = StTrap;
         end
         StWb, StBranch, StJump: w_state_d = StFetch;
         StTrap:   w_state_d = StTrap;
         default:  w_state_d = StIdle;
      endcase
      // Staying in FETCH/MEM means a cycle spent waiting; any state change clears the count.
      w_cnt_d = '0;
      if ((MEM_TIMEOUT != 0) && (w_state_d == r_state) &&
          ((r_state == StFetch) || (r_state == StMem))) begin
         w_cnt_d = r_cnt + 1'b1;
      end
   end

   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.pc_source     = 2'b00;
      bus.ir_write      = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.reg_write     = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.is_jal        = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = '0;
      bus.branch_type   = 3'b000;
      bus.illegal       = 1'b0;
      bus.state         = r_state;
      unique case (r_state)
         StFetch: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.alu_op    = ALUOP_W'(AluAdd);
            // PC+4 and IR load only commit in the cycle the fetch completes
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         StDecode: begin
            bus.alu_src_b = 2'b11;
            bus.alu_op    = ALUOP_W'(AluAdd);
         end
         StExec: begin
            bus.alu_src_a = 1'b1;
            if (w_rtype || w_seq) begin
               bus.alu_src_b = 2'b00;
               bus.alu_op    = ALUOP_W'(w_seq ? AluSeq : w_r_alu);
            end else begin
               bus.alu_src_b = 2'b10;
               bus.alu_op    = ALUOP_W'(w_itype ? w_i_alu : AluAdd);
            end
         end
         StMem: begin
            bus.iord      = 1'b1;
            bus.mem_read  = w_lw;
            bus.mem_write = w_sw;
         end
         StWb: begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = w_rtype || w_seq;
            bus.mem_to_reg = w_lw;
         end
         StBranch: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALUOP_W'(AluSub);
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
            bus.branch_type   = w_br_type;
         end
         StJump: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = w_jr ? 2'b11 : 2'b10;
            bus.reg_write = w_jal;
            bus.is_jal    = w_jal;
         end
         StTrap:  bus.illegal = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation MIPS control: a multi-cycle FSM that replaces the single-cycle opcode/funct decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath and a single memory port with a ready handshake.
- Adds a memory-latency watchdog, a sticky illegal-instruction trap and a parametrised custom-opcode enable.
- Sits between the instruction register (IR) and the datapath muxes, register file, ALU and memory port.

Parameters:
- ALUOP_W, 5, alu_op width (codes below use the low 5 bits, zero-extended).
- MEM_TIMEOUT, 16, maximum cycles waiting for mem_ready in FETCH/MEM before TRAP; 0 disables the watchdog.
- ENABLE_CUSTOM, 1, 1 decodes opcode 011111 (bgt..bgtu, seq); 0 makes it illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the branch condition holds.
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (jr).
- ir_write  out  1  latch memory data into IR.
- iord  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination: 1 rd, 0 rt.
- mem_to_reg  out  1  write-back source is memory data.
- is_jal  out  1  write PC+4 to $31.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm shifted left 2.
- alu_op  out  ALUOP_W  team ALU code.
- branch_type  out  3  000 beq, 001 bne, 010 bgt, 011 bgte, 100 ble, 101 bleq, 110 bleu, 111 bgtu.
- illegal  out  1  sticky trap flag.
- state  out  4  current state, for debug.

Behaviour:
- ALU codes: add 00000, sub 00001, addu 00010, subu 00011, and 01000, or 01001, xor 01010, sll 01100, srl 01101, sra 01110, lui 01111, slt 10000, seq 10001.
- States: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, BRANCH 6, JUMP 7, TRAP 8.
- All outputs are decoded from the registered state; pc_write and ir_write are additionally gated by mem_ready. Outputs not listed for a state are 0.
- Reset: state goes to IDLE immediately and asynchronously, all outputs 0, watchdog counter 0, illegal 0. Reset mid-access abandons the access; no write strobe persists.
- IDLE: goes to FETCH on the next clk.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
  - In the cycle mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE. Otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut).
  - Next state: R-type non-jr, addi/addiu/andi/ori/xori/lui, lw, sw and seq go to EXEC; beq/bne/custom branches go to BRANCH; j/jal/jr go to JUMP.
  - Undefined opcode, undefined R funct, undefined custom funct, or opcode 011111 with ENABLE_CUSTOM=0 go to TRAP.
- EXEC:
  - R-type and seq: alu_src_a=1, alu_src_b=00, alu_op from funct.
  - I-type: alu_src_a=1, alu_src_b=10, alu_op from opcode.
  - lw/sw: alu_src_a=1, alu_src_b=10, alu_op=add, then MEM. All other instructions go to WB.
- MEM:
  - iord=1; lw holds mem_read, sw holds mem_write, until mem_ready.
  - On mem_ready: lw goes to WB, sw goes to FETCH.
- WB: reg_write=1. reg_dst=1 for R-type and seq; reg_dst=0 for I-type and lw. mem_to_reg=1 for lw only. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_source=01, branch_type decoded. Then FETCH.
- JUMP:
  - pc_write=1; pc_source=10 for j/jal, 11 for jr.
  - jal additionally drives reg_write=1 and is_jal=1.
  - Then FETCH.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until rst.
- Watchdog:
  - Counter clears on entry to FETCH or MEM and increments each waiting cycle without mem_ready.
  - When the count equals MEM_TIMEOUT and mem_ready=0, go to TRAP next cycle.
  - mem_ready in that same cycle wins: the access completes normally.
- Latency, zero-wait memory: R/I = 4 cycles, lw = 5, sw = 4, branch = 3, jump = 3.

Test Plan:
- addi (opcode 001000), mem_ready tied 1 -> state sequence 1,2,3,5,1; alu_op=00000 and alu_src_b=10 in EXEC; reg_write=1 and reg_dst=0 in WB.
- lw with mem_ready low 3 cycles in MEM -> mem_read and iord held 4 cycles; WB has mem_to_reg=1; no reg_write before WB.
- jal -> JUMP cycle shows pc_write=1, pc_source=10, reg_write=1, is_jal=1; bgt (011111/010001) -> BRANCH with branch_type=010 and pc_write_cond=1.
- opcode 111111 -> TRAP; illegal=1 holds 20 cycles; rst pulse mid-trap -> IDLE with all outputs 0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 5 FETCH cycles; mem_ready=1 on the 5th cycle -> normal DECODE.
- ENABLE_CUSTOM=0, seq instruction -> TRAP; same instruction with ENABLE_CUSTOM=1 -> EXEC with alu_op=10001, then WB with reg_dst=1.
